// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: forwarding selects, load-use stall, branch flush
// Tracks rs/rd/write-enable through E/M/W and counts stall and flush cycles.
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic        RegWriteD,
  input  logic        LoadD,
  input  logic        PCSrcE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  logic [4:0] rs1e, rs2e, rde, rdm, rdw;
  logic       regwe, loade, regwm, regww;
  logic       lwstall;
  logic       flush_e_raw;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       regw_m,
    input logic [4:0] rd_w,
    input logic       regw_w
  );
    // M-stage result is younger, so it wins over W when both match
    if (regw_m && (rd_m != 5'd0) && (rd_m == rs))
      fwd_sel = 2'b10;
    else if (regw_w && (rd_w != 5'd0) && (rd_w == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  always_comb begin
    lwstall     = loade && (rde != 5'd0) && ((rde == Rs1D) || (rde == Rs2D)) && !PCSrcE;
    flush_e_raw = lwstall || PCSrcE;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    if (!rst) begin
      ForwardAE = fwd_sel(rs1e, rdm, regwm, rdw, regww);
      ForwardBE = fwd_sel(rs2e, rdm, regwm, rdw, regww);
      StallF    = lwstall;
      StallD    = lwstall;
      FlushD    = PCSrcE;
      FlushE    = flush_e_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1e       <= 5'd0;
      rs2e       <= 5'd0;
      rde        <= 5'd0;
      regwe      <= 1'b0;
      loade      <= 1'b0;
      rdm        <= 5'd0;
      regwm      <= 1'b0;
      rdw        <= 5'd0;
      regww      <= 1'b0;
      StallCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      // a flushed E slot becomes a bubble, which is what ends a load-use stall
      if (flush_e_raw) begin
        rs1e  <= 5'd0;
        rs2e  <= 5'd0;
        rde   <= 5'd0;
        regwe <= 1'b0;
        loade <= 1'b0;
      end else begin
        rs1e  <= Rs1D;
        rs2e  <= Rs2D;
        rde   <= RdD;
        regwe <= RegWriteD;
        loade <= LoadD;
      end
      rdm   <= rde;
      regwm <= regwe;
      rdw   <= rdm;
      regww <= regwm;
      if (lwstall && (StallCount != 16'hFFFF))
        StallCount <= StallCount + 16'd1;
      if (PCSrcE && (FlushCount != 16'hFFFF))
        FlushCount <= FlushCount + 16'd1;
    end
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: none; register-address width fixed at 5 bits, counter width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Rs1D  input  5  source register 1 of instruction in Decode.
REQ-005 Rs2D  input  5  source register 2 of instruction in Decode.
REQ-006 RdD  input  5  destination register of instruction in Decode.
REQ-007 RegWriteD  input  1  Decode instruction writes register file.
REQ-008 LoadD  input  1  Decode instruction is a load (ResultSrc selects memory).
REQ-009 PCSrcE  input  1  branch/jump taken, resolved in Execute.
REQ-010 ForwardAE  output  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM.
REQ-011 ForwardBE  output  2  SrcB select, same encoding as ForwardAE.
REQ-012 StallF  output  1  hold PC register.
REQ-013 StallD  output  1  hold IF/ID register.
REQ-014 FlushD  output  1  clear IF/ID register.
REQ-015 FlushE  output  1  clear ID/EX register.
REQ-016 StallCount  output  16  number of load-use stall cycles since reset.
REQ-017 FlushCount  output  16  number of taken-branch flush cycles since reset.

Function
REQ-018 Internal tracking pipeline SHALL mirror the datapath: E-stage regs {rs1E, rs2E, rdE, regwE, loadE}, M-stage regs {rdM, regwM}, W-stage regs {rdW, regwW}.
REQ-019 Each edge: if FlushE, all E-stage regs <= 0; else E-stage <= {Rs1D, Rs2D, RdD, RegWriteD, LoadD}.
REQ-020 Each edge: {rdM, regwM} <= {rdE, regwE}; {rdW, regwW} <= {rdM, regwM}; no stall or flush applies to M/W.
REQ-021 ForwardAE = 10 when regwM && rdM != 0 && rdM == rs1E; else 01 when regwW && rdW != 0 && rdW == rs1E; else 00.
REQ-022 ForwardBE uses the same rule with rs2E.
REQ-023 M-stage match SHALL take priority over W-stage match when both hit the same register.
REQ-024 Register x0 SHALL never be forwarded; rd == 0 always yields 00.
REQ-025 lwStall = loadE && rdE != 0 && (rdE == Rs1D || rdE == Rs2D) && !PCSrcE.
REQ-026 StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall || PCSrcE.
REQ-027 All outputs except the counters SHALL be combinational from current inputs and tracking regs; zero added latency.
REQ-028 Stall SHALL last exactly one cycle per load-use hazard; the bubble inserted into E clears loadE, so lwStall deasserts on the next cycle.
REQ-029 PCSrcE and load-use simultaneous: PCSrcE wins; lwStall suppressed; FlushD = FlushE = 1, StallF = StallD = 0.
REQ-030 StallCount increments by 1 on each edge where lwStall = 1; FlushCount increments by 1 on each edge where PCSrcE = 1.
REQ-031 Both counters SHALL saturate at 0xFFFF, with no wrap-around.

Reset
REQ-032 While rst = 1, all tracking regs and both counters SHALL be set to 0 on the edge.
REQ-033 While rst = 1, outputs SHALL be forced: ForwardAE = ForwardBE = 00, StallF = StallD = FlushD = FlushE = 0.
REQ-034 Reset asserted during a stall or flush SHALL abandon it; the first cycle after reset has no hazard in flight.

Verification
REQ-035 Back-to-back ALU dependency: add x5 in D, then add x6,x5,x1 in D next cycle -> the following cycle ForwardAE = 10; one cycle later, with a dependent instruction in E, ForwardAE = 01.
REQ-036 Load-use: lw x7 (LoadD = 1, RdD = 7), then Rs1D = 7 -> StallF = StallD = FlushE = 1 for exactly 1 cycle, StallCount = 1, then ForwardAE = 01 when the consumer reaches E.
REQ-037 x0 destination: RegWriteD = 1, RdD = 0, then Rs1D = Rs2D = 0 -> ForwardAE = ForwardBE = 00 throughout, no stall.
REQ-038 Double hit: x3 written in M and in W, rs2E = 3 -> ForwardBE = 10.
REQ-039 Simultaneous: loadE with a matching Rs1D and PCSrcE = 1 -> FlushD = FlushE = 1, StallF = 0, FlushCount +1, StallCount unchanged.
REQ-040 Saturation and reset: preload counters to 0xFFFF via 65535 branch cycles, one more PCSrcE -> FlushCount stays 0xFFFF; assert rst mid-stall -> all outputs 0 and counters 0 next cycle.
